// File: rtl/operand_fetch_pkg.sv
// Shared widths, select encoding and the latched instruction record for the
// operand fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int OPC_W    = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Register file select encoding
  localparam logic SEL_READ  = 1'b1;
  localparam logic SEL_WRITE = 1'b0;

  // One decoded instruction as held in the single-entry latch
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              write_en;
  } instr_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set when an
// instruction that writes rd issues, cleared when its writeback lands.
module operand_fetch_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              busy_rs1_o,
  output logic              busy_rs2_o,
  output logic              busy_rd_o
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;

  // Next pending vector: clear the writeback target, then mark the new issue
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
  end

  // Pending vector register with synchronous reset
  // NOTE: reset is sampled only on the clock edge, so it sits inside the
  // clocked branch rather than in the sensitivity list; state uses <= only.
  always_ff @(posedge clk) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  assign busy_rs1_o = pend_q[rs1_i];
  assign busy_rs2_o = pend_q[rs2_i];
  assign busy_rd_o  = pend_q[rd_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: latches one decoded instruction, arbitrates the
// register file port between writebacks and operand reads, stalls on
// scoreboard hazards and presents registered operands to execute.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [OPC_W-1:0]  inOpcode,
  input  logic [ADDR_W-1:0] inRs1,
  input  logic [ADDR_W-1:0] inRs2,
  input  logic [ADDR_W-1:0] inRd,
  input  logic              inWriteEn,
  input  logic              wbValid,
  input  logic [ADDR_W-1:0] wbAddress,
  input  logic [DATA_W-1:0] wbData,
  output logic              select,
  output logic [ADDR_W-1:0] readAddress1,
  output logic [ADDR_W-1:0] readAddress2,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  output logic              outValid,
  input  logic              outReady,
  output logic [OPC_W-1:0]  outOpcode,
  output logic [ADDR_W-1:0] outRd,
  output logic              outWriteEn,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB
);

  instr_t            lat_q;
  logic              lat_full_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              out_valid_q;
  instr_t            out_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;

  logic busy_rs1, busy_rs2, busy_rd;
  logic hazard;
  logic fire;
  logic in_fire;

  operand_fetch_scoreboard u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_en_i   (fire && lat_q.write_en),
    .set_addr_i (lat_q.rd),
    .clr_en_i   (wbValid),
    .clr_addr_i (wbAddress),
    .rs1_i      (lat_q.rs1),
    .rs2_i      (lat_q.rs2),
    .rd_i       (lat_q.rd),
    .busy_rs1_o (busy_rs1),
    .busy_rs2_o (busy_rs2),
    .busy_rd_o  (busy_rd)
  );

  assign hazard  = busy_rs1 | busy_rs2 | (lat_q.write_en & busy_rd);
  assign fire    = lat_full_q & ~wbValid & ~hazard & (~out_valid_q | outReady);
  assign inReady = reset_n & (~lat_full_q | fire);
  assign in_fire = inValid & inReady;

  // Port arbitration: writeback wins; otherwise present the latched sources
  // NOTE: every output gets a value on every path, so no latch is inferred;
  // the "hold last write" behaviour comes from the wr_*_q flops instead.
  always_comb begin
    select       = SEL_READ;
    writeAddress = wr_addr_q;
    writeData    = wr_data_q;
    readAddress1 = lat_full_q ? lat_q.rs1 : '0;
    readAddress2 = lat_full_q ? lat_q.rs2 : '0;
    if (wbValid) begin
      select       = SEL_WRITE;
      writeAddress = wbAddress;
      writeData    = wbData;
    end
  end

  // Remember the last write so the write port holds it during read cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (wbValid) begin
      wr_addr_q <= wbAddress;
      wr_data_q <= wbData;
    end
  end

  // Single-entry instruction latch: fills on accept, empties on issue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_full_q <= 1'b0;
      lat_q      <= '0;
    end else if (in_fire) begin
      lat_full_q <= 1'b1;
      lat_q      <= '{opcode: inOpcode, rs1: inRs1, rs2: inRs2,
                      rd: inRd, write_en: inWriteEn};
    end else if (fire) begin
      lat_full_q <= 1'b0;
    end
  end

  // Output register: reload on issue, drop valid on accept without issue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_q       <= lat_q;
      op_a_q      <= readData1;
      op_b_q      <= readData2;
    end else if (outReady) begin
      out_valid_q <= 1'b0;
    end
  end

  assign outValid   = out_valid_q;
  assign outOpcode  = out_q.opcode;
  assign outRd      = out_q.rd;
  assign outWriteEn = out_q.write_en;
  assign opA        = op_a_q;
  assign opB        = op_b_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage directly upstream of the 32x16 register file.
- Accepts decoded instructions (opcode, rs1, rs2, rd) over a valid/ready handshake.
- Drives the register file's single select/address/data interface, arbitrating between operand reads and writeback writes.
- Tracks pending destination registers in a scoreboard, and presents operands to the execute stage over a second valid/ready handshake.

Parameters:
DATA_W, 16, register data width
ADDR_W, 5, register address width (32 registers)
OPC_W, 4, opcode width carried through

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
inValid  input  1  decode has an instruction
inReady  output  1  stage can accept an instruction
inOpcode  input  OPC_W  opcode
inRs1  input  ADDR_W  source 1 address
inRs2  input  ADDR_W  source 2 address
inRd  input  ADDR_W  destination address
inWriteEn  input  1  instruction will write rd
wbValid  input  1  writeback request (always accepted)
wbAddress  input  ADDR_W  writeback address
wbData  input  DATA_W  writeback data
select  output  1  to register file: 1=read, 0=write
readAddress1  output  ADDR_W  to register file
readAddress2  output  ADDR_W  to register file
writeAddress  output  ADDR_W  to register file
writeData  output  DATA_W  to register file
readData1  input  DATA_W  from register file (combinational)
readData2  input  DATA_W  from register file (combinational)
outValid  output  1  operands valid
outReady  input  1  execute accepts operands
outOpcode  output  OPC_W  registered opcode
outRd  output  ADDR_W  registered rd
outWriteEn  output  1  registered write enable
opA  output  DATA_W  registered operand 1
opB  output  DATA_W  registered operand 2

Behaviour:
- Reset values: all state updates only on a clk edge with reset_n=0.
  - Instruction latch empty; scoreboard all zero.
  - outValid=0; opA/opB/outOpcode/outRd/outWriteEn all 0.
  - select=1; readAddress1/2, writeAddress and writeData all 0.
- Reset mid-operation discards the latched instruction, any pending output and all scoreboard bits.
- Instruction latch (1 entry):
  - Loads on inValid&inReady.
  - inReady = !latchFull || fire.
  - While reset_n=0, inReady=0.
- Register file port arbitration (combinational, per cycle):
  - wbValid=1: select=0; writeAddress=wbAddress; writeData=wbData; scoreboard[wbAddress] cleared at the edge. Writeback always has priority; no ready is returned.
  - Otherwise: select=1; readAddress1/2 = latched rs1/rs2, or 0 when the latch is empty. writeAddress and writeData hold their last values.
- hazard = scoreboard[rs1] | scoreboard[rs2] | (writeEn & scoreboard[rd]). The rd term is a WAW stall.
- fire = latchFull & !wbValid & !hazard & (!outValid | outReady).
- On fire, at the edge:
  - opA<=readData1, opB<=readData2.
  - outOpcode, outRd and outWriteEn load from the latch.
  - outValid<=1.
  - If writeEn, scoreboard[rd]<=1.
  - Latency: one cycle from a fire cycle to outValid.
- Output handshake: outValid&outReady with no fire clears outValid. Simultaneous accept and fire reloads the output register, keeping outValid=1, for one instruction per cycle throughput.
- Output stability: while outValid&!outReady, all out* outputs are held stable.
- No same-cycle forwarding: a read never occurs in a wb cycle. The scoreboard guarantees a read issues only after the producing write has landed.
- Scoreboard collisions: set and clear on the same address in one cycle cannot occur, because fire excludes wbValid. A wb to a non-pending address is legal; it writes and the clear has no effect.
- Register 0 is not special.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W, OPC_W and NUM_REGS=2**ADDR_W.
  - Select encoding constants: SEL_READ=1, SEL_WRITE=0.
- One natural sub-module: scoreboard. It holds the 32-bit pending vector, with set/clear ports and three combinational lookup outputs.

Test Plan:
- Reset, then wb r1=15 and wb r3=10 in two cycles -> select=0 both cycles, then select=1; the register file holds 15 and 10.
- Instr rs1=1, rs2=3, rd=5, writeEn=1 with outReady=1 -> outValid the next cycle, opA=15, opB=10, outRd=5; scoreboard[5]=1.
- Follow-up instr rs1=5 -> stalls with inReady=0 and outValid not reasserted until wb r5=25 arrives. It then fires the cycle after the wb, with opA=25.
- wbValid held high 3 cycles while an instr is latched -> no fire and select=0 for all 3 cycles. The instr fires on cycle 4.
- outReady=0 with two back-to-back instrs -> first output held stable; second latched with inReady=0; drains in order once outReady=1.
- Assert reset_n=0 with scoreboard[5]=1 and outValid=1 -> next cycle outValid=0 and the scoreboard is clear. A fresh instr reading r5 then fires without stalling.
